// File: rtl/ls_seq.sv
// Load/store sequencer: turns one byte/halfword/word access into memory cycles,
// with read-modify-write for sub-word stores and extension for sub-word loads.
module ls_seq #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LB  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_SW  = 3'b100;
   localparam logic [2:0] OP_SH  = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_LBU = 3'b111;

   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic misaligned(input logic [2:0] f_op, input logic [1:0] f_ofs);
      case (f_op)
         OP_LW, OP_SW:          misaligned = (f_ofs != 2'b00);
         OP_LH, OP_LHU, OP_SH:  misaligned = f_ofs[0];
         default:               misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f_op, input logic [1:0] f_ofs,
                                            input logic [31:0] f_word);
      logic [31:0] lane;
      lane = f_word >> {f_ofs, 3'b000};
      case (f_op)
         OP_LH:   load_ext = {{16{lane[15]}}, lane[15:0]};
         OP_LHU:  load_ext = {16'h0000, lane[15:0]};
         OP_LB:   load_ext = {{24{lane[7]}}, lane[7:0]};
         OP_LBU:  load_ext = {24'h000000, lane[7:0]};
         default: load_ext = f_word;
      endcase
   endfunction

   // Replace the addressed lane of the old word, leaving the other lanes intact.
   function automatic logic [31:0] merge_word(input logic [2:0] f_op, input logic [1:0] f_ofs,
                                              input logic [31:0] f_old, input logic [31:0] f_new);
      logic [31:0] mask;
      logic [31:0] ins;
      case (f_op)
         OP_SB: begin
            mask = 32'h0000_00FF << {f_ofs, 3'b000};
            ins  = {24'h000000, f_new[7:0]} << {f_ofs, 3'b000};
         end
         OP_SH: begin
            mask = 32'h0000_FFFF << {f_ofs, 3'b000};
            ins  = {16'h0000, f_new[15:0]} << {f_ofs, 3'b000};
         end
         default: begin
            mask = 32'h0000_0000;
            ins  = 32'h0000_0000;
         end
      endcase
      merge_word = (f_old & ~mask) | (ins & mask);
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  ofs_q, ofs_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        mem_wr_q, mem_wr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   // Next-state and next-output logic; all outputs are registered from here.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ofs_d       = ofs_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wr_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d    = op;
               ofs_d   = addr[1:0];
               wdata_d = wdata;
               if (misaligned(op, addr[1:0])) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (op == OP_SW) begin
                  state_d     = S_WRITE;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata;
                  mem_wr_d    = 1'b1;
               end else begin
                  state_d    = S_READ;
                  mem_addr_d = {addr[31:2], 2'b00};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 3'd0) begin
               if ((op_q == OP_SB) || (op_q == OP_SH)) begin
                  mem_wdata_d = merge_word(op_q, ofs_q, mem_rdata, wdata_q);
                  mem_wr_d    = 1'b1;
                  state_d     = S_WRITE;
               end else begin
                  rdata_d = load_ext(op_q, ofs_q, mem_rdata);
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_WRITE: begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_WRITE);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= 3'b000;
         ofs_q       <= 2'b00;
         wdata_q     <= 32'h0000_0000;
         cnt_q       <= 3'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         mem_addr_q  <= 32'h0000_0000;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ofs_q       <= ofs_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ls_seq.sv
// Bench for ls_seq: two instances (read latency 1 and 3), each with a small word memory.
module tb_ls_seq;

   localparam logic [2:0] LW = 3'b000, LH = 3'b001, LB = 3'b010, LHU = 3'b011;
   localparam logic [2:0] SW = 3'b100, SH = 3'b101, SB = 3'b110, LBU = 3'b111;

   typedef struct {
      logic        sel;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          done_cyc;
      int          wr_cyc;
      logic [31:0] waddr;
      logic [31:0] wd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        sel = 1'b0;
   logic        load_mem = 1'b1;
   logic [2:0]  op = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;

   logic        req_a, busy_a, done_a, err_a, mem_wr_a;
   logic        req_b, busy_b, done_b, err_b, mem_wr_b;
   logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic        o_busy, o_done, o_err, o_mem_wr;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;

   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [3];

   int   checks = 0;
   int   errors = 0;
   vec_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   assign req_a = req & ~sel;
   assign req_b = req & sel;

   ls_seq #(.MEM_LAT(1)) dut_a (
      .clock(clk), .reset(reset), .req(req_a), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy_a), .done(done_a), .err(err_a), .rdata(rdata_a),
      .mem_addr(mem_addr_a), .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
   );

   ls_seq #(.MEM_LAT(3)) dut_b (
      .clock(clk), .reset(reset), .req(req_b), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy_b), .done(done_b), .err(err_b), .rdata(rdata_b),
      .mem_addr(mem_addr_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   assign o_busy      = sel ? busy_b      : busy_a;
   assign o_done      = sel ? done_b      : done_a;
   assign o_err       = sel ? err_b       : err_a;
   assign o_mem_wr    = sel ? mem_wr_b    : mem_wr_a;
   assign o_rdata     = sel ? rdata_b     : rdata_a;
   assign o_mem_addr  = sel ? mem_addr_b  : mem_addr_a;
   assign o_mem_wdata = sel ? mem_wdata_b : mem_wdata_a;

   // Memory models: read data lags the address by the instance's latency.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 64; i++) begin
            mem_a[i] <= 32'h0;
            mem_b[i] <= 32'h0;
         end
         mem_a[16] <= 32'h8899AABB;
         mem_b[16] <= 32'h8899AABB;
      end else begin
         if (mem_wr_a) mem_a[mem_addr_a[7:2]] <= mem_wdata_a;
         if (mem_wr_b) mem_b[mem_addr_b[7:2]] <= mem_wdata_b;
      end
      pipe_a    <= mem_addr_a;
      pipe_b[0] <= mem_addr_b;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end

   assign mem_rdata_a = mem_a[pipe_a[7:2]];
   assign mem_rdata_b = mem_b[pipe_b[2][7:2]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      vec_t        e;
      int          cyc, wr_n, wr_c;
      logic        got, busy_ok;
      logic [31:0] wa, wd, a1;
      exp_q.push_back(v);
      sel   = v.sel;
      op    = v.op;
      addr  = v.addr;
      wdata = v.wdata;
      req   = 1'b1;
      step();
      req = 1'b0;
      cyc = 1; got = 1'b0; busy_ok = 1'b1;
      wr_n = 0; wr_c = 0; wa = 32'h0; wd = 32'h0;
      a1 = o_mem_addr;
      while (!got && cyc < 40) begin
         if (o_mem_wr) begin
            wr_n++;
            wr_c = cyc;
            wa   = o_mem_addr;
            wd   = o_mem_wdata;
         end
         if (o_done) got = 1'b1;
         else begin
            if (!o_busy) busy_ok = 1'b0;
            step();
            cyc++;
         end
      end
      e = exp_q.pop_front();
      check($sformatf("done_seen op%0d @%h", e.op, e.addr), {31'b0, got}, 32'h1);
      check($sformatf("done_cyc op%0d @%h", e.op, e.addr), cyc, e.done_cyc);
      check($sformatf("err op%0d @%h", e.op, e.addr), {31'b0, o_err}, {31'b0, e.err});
      check($sformatf("rdata op%0d @%h", e.op, e.addr), o_rdata, e.rdata);
      check($sformatf("busy op%0d @%h", e.op, e.addr), {30'b0, busy_ok, o_busy}, 32'h2);
      if (e.wr_cyc != 0) begin
         check($sformatf("wr_count op%0d @%h", e.op, e.addr), wr_n, 1);
         check($sformatf("wr_cyc op%0d @%h", e.op, e.addr), wr_c, e.wr_cyc);
         check($sformatf("wr_addr op%0d @%h", e.op, e.addr), wa, e.waddr);
         check($sformatf("wr_data op%0d @%h", e.op, e.addr), wd, e.wd);
      end else begin
         check($sformatf("no_wr op%0d @%h", e.op, e.addr), wr_n, 0);
      end
      if (!e.err) check($sformatf("mem_addr_c1 op%0d @%h", e.op, e.addr), a1, {e.addr[31:2], 2'b00});
      step();
   endtask

   initial begin
      int          n, d1, d2, cyc;

      // sel, op, addr, wdata, exp rdata, err, done cycle, write cycle, write addr, write data
      vecs.push_back('{1'b0, LB,  32'h41, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LBU, 32'h41, 32'h0,        32'h000000AA, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LH,  32'h42, 32'h0,        32'hFFFF8899, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LHU, 32'h42, 32'h0,        32'h00008899, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LW,  32'h40, 32'h0,        32'h8899AABB, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, SB,  32'h43, 32'h123456CC, 32'h8899AABB, 1'b0, 4, 3, 32'h40, 32'hCC99AABB});
      vecs.push_back('{1'b0, LW,  32'h40, 32'h0,        32'hCC99AABB, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, SW,  32'h40, 32'h8899AABB, 32'hCC99AABB, 1'b0, 2, 1, 32'h40, 32'h8899AABB});
      vecs.push_back('{1'b0, SH,  32'h40, 32'h0000BEEF, 32'hCC99AABB, 1'b0, 4, 3, 32'h40, 32'h8899BEEF});
      vecs.push_back('{1'b0, SW,  32'h44, 32'hDEADBEEF, 32'hCC99AABB, 1'b0, 2, 1, 32'h44, 32'hDEADBEEF});
      vecs.push_back('{1'b0, LW,  32'h42, 32'h0,        32'hCC99AABB, 1'b1, 1, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, SH,  32'h41, 32'h1111,     32'hCC99AABB, 1'b1, 1, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LHU, 32'h43, 32'h0,        32'hCC99AABB, 1'b1, 1, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, SW,  32'h46, 32'h5555,     32'hCC99AABB, 1'b1, 1, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LW,  32'h44, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LB,  32'h47, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LH,  32'h40, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b0, LBU, 32'h40, 32'h0,        32'h000000EF, 1'b0, 3, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, LB,  32'h41, 32'h0,        32'hFFFFFFAA, 1'b0, 5, 0, 32'h0,  32'h0});
      vecs.push_back('{1'b1, SB,  32'h42, 32'h00000077, 32'hFFFFFFAA, 1'b0, 6, 5, 32'h40, 32'h8877AABB});
      vecs.push_back('{1'b1, LW,  32'h40, 32'h0,        32'h8877AABB, 1'b0, 5, 0, 32'h0,  32'h0});

      repeat (2) step();
      check("reset busy", {31'b0, busy_a}, 32'h0);
      check("reset done", {31'b0, done_a}, 32'h0);
      check("reset err", {31'b0, err_a}, 32'h0);
      check("reset mem_wr", {31'b0, mem_wr_a}, 32'h0);
      check("reset rdata", rdata_a, 32'h0);
      check("reset mem_addr", mem_addr_a, 32'h0);
      check("reset mem_wdata", mem_wdata_a, 32'h0);
      load_mem = 1'b0;
      reset    = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // req held high through DONE: second access must wait for IDLE.
      sel = 1'b1; op = LW; addr = 32'h40; req = 1'b1;
      step();
      cyc = 1; n = 0; d1 = 0; d2 = 0;
      while (n < 2 && cyc < 40) begin
         if (o_done) begin
            n++;
            if (n == 1) d1 = cyc;
            else d2 = cyc;
         end
         if (n < 2) begin
            step();
            cyc++;
         end
      end
      req = 1'b0;
      check("held_req first done", d1, 5);
      check("held_req second done", d2, 11);
      check("held_req rdata", rdata_b, 32'h8877AABB);
      step();

      // Reset asserted during the WRITE cycle of SB aborts the access.
      sel = 1'b0; op = SB; addr = 32'h40; wdata = 32'h11; req = 1'b1;
      step();
      req = 1'b0;
      step();
      step();
      check("rst_mid wr before reset", {31'b0, mem_wr_a}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_mid mem_wr", {31'b0, mem_wr_a}, 32'h0);
      check("rst_mid busy", {31'b0, busy_a}, 32'h0);
      step();
      check("rst_mid no done", {31'b0, done_a}, 32'h0);
      check("rst_mid rdata", rdata_a, 32'h0);
      step();
      reset = 1'b1;
      step();
      check("rst_mid no late done", {31'b0, done_a}, 32'h0);
      run_vec('{1'b0, LW, 32'h40, 32'h0, 32'h8899BEEF, 1'b0, 3, 0, 32'h0, 32'h0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
